// File: rtl/cosinus_arbiter.sv
// cosinus_arbiter
//
// Shares a single Cosinus datapath among NREQ requesters using round-robin
// arbitration. The winner's operands are latched and presented to the unit
// with a one-cycle start pulse. The arbiter then waits for the unit's ready
// flag. The captured result is returned to the winner together with a
// one-cycle one-hot ack.
//
// Build option: define COS_TIMEOUT_EN to add a WAIT-state watchdog. When the
// unit has not raised ready after TIMEOUT_CYCLES cycles in WAIT, the arbiter
// completes the transaction with rsp_result=0 and rsp_err=1. This option also
// adds the TIMEOUT_CYCLES parameter and the rsp_err port.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req               per-requester request level
//   req_x, req_y      flattened operands, slice i = [i*W +: W]
//   ack               one-hot completion pulse, one cycle
//   rsp_result        result, valid while ack != 0
//   rsp_id            index of the acked requester
//   rsp_err           (COS_TIMEOUT_EN only) watchdog expiry flag, valid with ack
//   busy              high in every state except IDLE
//   cos_start         start pulse to the Cosinus unit
//   cos_x, cos_y      operands to the unit, stable from ISSUE through WAIT
//   cos_ready         unit done/idle flag
//   cos_result        unit result

module cosinus_arbiter #(
  parameter int NREQ = 4,
  parameter int XW   = 10,
  parameter int YW   = 8,
  parameter int RW   = 10
`ifdef COS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*XW-1:0]     req_x,
  input  logic [NREQ*YW-1:0]     req_y,
  output logic [NREQ-1:0]        ack,
  output logic [RW-1:0]          rsp_result,
  output logic [$clog2(NREQ)-1:0] rsp_id,
`ifdef COS_TIMEOUT_EN
  output logic                   rsp_err,
`endif
  output logic                   busy,
  output logic                   cos_start,
  output logic [XW-1:0]          cos_x,
  output logic [YW-1:0]          cos_y,
  input  logic                   cos_ready,
  input  logic [RW-1:0]          cos_result
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   last_reg;      // most recent grant, arbitration starts after it
  logic [IW-1:0]   g_reg;         // requester owning the current transaction
  logic [RW-1:0]   result_reg;
  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic            wait_done;

  logic [XW-1:0]   x_slice [NREQ];
  logic [YW-1:0]   y_slice [NREQ];

  // Unpack the flattened operand buses and build the one-hot ack.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign x_slice[gi] = req_x[gi*XW +: XW];
      assign y_slice[gi] = req_y[gi*YW +: YW];
      assign ack[gi]     = (state_reg == S_RESP) && (g_reg == IW'(gi));
    end
  endgenerate

  // Round-robin pick: first set bit scanning last+1, last+2, ... modulo NREQ.
  // The scan ends at last itself, so a lone requester can be re-granted.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = last_reg;
    idx         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_reg) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!grant_found && req[idx[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[IW-1:0];
      end
    end
  end

`ifdef COS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_reg;
  logic          timeout_hit;

  // wait_cnt_reg counts WAIT cycles already spent. Expiry at TIMEOUT_CYCLES-1
  // places ack exactly TIMEOUT_CYCLES cycles after WAIT entry.
  assign timeout_hit = (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
  assign wait_done   = cos_ready || timeout_hit;
`else
  assign wait_done   = cos_ready;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (grant_found) state_next = S_ISSUE;
      S_ISSUE: state_next = S_ARM;
      S_ARM:   state_next = S_WAIT;   // ready is ignored for this cycle
      S_WAIT:  if (wait_done) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      last_reg   <= IW'(NREQ - 1);
      g_reg      <= '0;
      result_reg <= '0;
      cos_x      <= '0;
      cos_y      <= '0;
`ifdef COS_TIMEOUT_EN
      wait_cnt_reg <= '0;
      rsp_err      <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            g_reg    <= grant_idx;
            last_reg <= grant_idx;
            cos_x    <= x_slice[grant_idx];
            cos_y    <= y_slice[grant_idx];
          end
        end
`ifdef COS_TIMEOUT_EN
        S_ARM: begin
          wait_cnt_reg <= '0;
        end
        S_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (cos_ready) begin
            result_reg <= cos_result;
            rsp_err    <= 1'b0;
          end else if (timeout_hit) begin
            result_reg <= '0;
            rsp_err    <= 1'b1;
          end
        end
`else
        S_WAIT: begin
          if (cos_ready) begin
            result_reg <= cos_result;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Decoded from the state register so that an asynchronous reset clears
  // these outputs immediately.
  assign cos_start  = (state_reg == S_ISSUE);
  assign busy       = (state_reg != S_IDLE);
  assign rsp_result = result_reg;
  assign rsp_id     = g_reg;

endmodule

// File: tb/tb_cosinus_arbiter.sv
`timescale 1ns/1ps
module tb_cosinus_arbiter;

  localparam int NREQ = 4;
  localparam int XW   = 10;
  localparam int YW   = 8;
  localparam int RW   = 10;
  localparam int IW   = 2;
  localparam int TMO  = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*XW-1:0]   req_x = '0;
  logic [NREQ*YW-1:0]   req_y = '0;
  logic [NREQ-1:0]      ack;
  logic [RW-1:0]        rsp_result;
  logic [IW-1:0]        rsp_id;
  logic                 busy;
  logic                 cos_start;
  logic [XW-1:0]        cos_x;
  logic [YW-1:0]        cos_y;
  logic                 cos_ready = 1'b1;
  logic [RW-1:0]        cos_result = '0;
`ifdef COS_TIMEOUT_EN
  logic                 rsp_err;
`endif

  always #5 clk = ~clk;

  cosinus_arbiter #(.NREQ(NREQ), .XW(XW), .YW(YW), .RW(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .ack        (ack),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
`ifdef COS_TIMEOUT_EN
    .rsp_err    (rsp_err),
`endif
    .busy       (busy),
    .cos_start  (cos_start),
    .cos_x      (cos_x),
    .cos_y      (cos_y),
    .cos_ready  (cos_ready),
    .cos_result (cos_result)
  );

  // Reference function of the behavioural Cosinus unit.
  function automatic logic [RW-1:0] cos_f(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return x + 10'h1A4 + {2'b00, y};
  endfunction

  // Behavioural unit: on start, ready drops and returns model_lat edges later.
  // model_lat == 0 means the unit never becomes ready again.
  int model_lat = 20;
  int model_cnt = 0;
  always @(posedge clk) begin
    if (cos_start) begin
      cos_ready  <= 1'b0;
      model_cnt  <= model_lat;
      cos_result <= cos_f(cos_x, cos_y);
    end else if (!cos_ready && model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) cos_ready <= 1'b1;
    end
  end

  typedef struct packed {
    logic [IW-1:0] id;
    logic [RW-1:0] res;
    logic          err;
  } rsp_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } op_t;

  rsp_t            rsp_q[$];
  op_t             op_q[$];
  int              tests = 0;
  int              fails = 0;
  int              acks_seen = 0;
  logic [NREQ-1:0] sticky = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of monitoring: compare start operands and responses against
  // the scoreboard, and drop acked requests that are not held on purpose.
  task automatic step();
    rsp_t e;
    op_t  o;
    @(negedge clk);
    if (cos_start !== 1'b0) begin
      if (op_q.size() == 0) begin
        check("unexpected_start", 32'(cos_start), 32'd0);
      end else begin
        o = op_q.pop_front();
        check("cos_x", 32'(cos_x), 32'(o.x));
        check("cos_y", 32'(cos_y), 32'(o.y));
      end
    end
    if (ack !== '0) begin
      acks_seen++;
      if (rsp_q.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("ack", 32'(ack), 32'(1) << e.id);
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", 32'(rsp_result), 32'(e.res));
`ifdef COS_TIMEOUT_EN
        check("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
        $display("[TB] ack id=%0d result=%0h", rsp_id, rsp_result);
      end
      req = req & (~ack | sticky);
    end
  endtask

  task automatic wait_acks(input int n, input int budget, output int cyc);
    int target;
    target = acks_seen + n;
    cyc = 0;
    while (acks_seen < target && cyc < budget) begin
      step();
      cyc++;
    end
    if (acks_seen < target) check("ack_timeout", 32'(acks_seen), 32'(target));
  endtask

  task automatic set_req(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y);
    req[i] = 1'b1;
    req_x[i*XW +: XW] = x;
    req_y[i*YW +: YW] = y;
  endtask

  task automatic expect_txn(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                            input logic [RW-1:0] res, input logic err);
    op_t  o;
    rsp_t r;
    o.x = x;
    o.y = y;
    r.id = IW'(i);
    r.res = res;
    r.err = err;
    op_q.push_back(o);
    rsp_q.push_back(r);
  endtask

  logic [XW-1:0] xs [NREQ];

  initial begin
    int cyc;
    xs[0] = 10'h080; xs[1] = 10'h100; xs[2] = 10'h180; xs[3] = 10'h200;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_start", 32'(cos_start), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    check("reset_cos_x", 32'(cos_x), 32'd0);
    rst = 1'b0;

    // All four requesters at once: service order 0,1,2,3
    model_lat = 6;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, xs[i], 8'(i + 1));
      expect_txn(i, xs[i], 8'(i + 1), cos_f(xs[i], 8'(i + 1)), 1'b0);
    end
    wait_acks(4, 200, cyc);
    check("all4_starts_consumed", 32'(op_q.size()), 32'd0);

    // Fairness: req0 held continuously, req2 once -> 0,2,0,0
    sticky[0] = 1'b1;
    set_req(0, 10'h050, 8'h10);
    set_req(2, 10'h2C0, 8'h20);
    expect_txn(0, 10'h050, 8'h10, cos_f(10'h050, 8'h10), 1'b0);
    expect_txn(2, 10'h2C0, 8'h20, cos_f(10'h2C0, 8'h20), 1'b0);
    expect_txn(0, 10'h050, 8'h10, cos_f(10'h050, 8'h10), 1'b0);
    expect_txn(0, 10'h050, 8'h10, cos_f(10'h050, 8'h10), 1'b0);
    wait_acks(3, 200, cyc);
    sticky[0] = 1'b0;
    wait_acks(1, 100, cyc);
    step();

    // Single request with a 20-cycle unit
    model_lat = 20;
    set_req(0, 10'h100, 8'h01);
    expect_txn(0, 10'h100, 8'h01, 10'h2A5, 1'b0);
    wait_acks(1, 100, cyc);
    step();
    check("busy_after_ack", 32'(busy), 32'd0);

    // Minimum latency: unit ready again by WAIT -> ack 4 cycles after sampling
    model_lat = 1;
    set_req(0, 10'h001, 8'h02);
    expect_txn(0, 10'h001, 8'h02, cos_f(10'h001, 8'h02), 1'b0);
    wait_acks(1, 20, cyc);
    check("min_latency", 32'(cyc), 32'd4);
    step();

    // Operands change after grant: cos_x must hold
    model_lat = 20;
    set_req(1, 10'h180, 8'h33);
    expect_txn(1, 10'h180, 8'h33, cos_f(10'h180, 8'h33), 1'b0);
    repeat (8) step();
    req_x[1*XW +: XW] = 10'h3FF;
    step();
    check("cos_x_hold", 32'(cos_x), 32'h180);
    wait_acks(1, 100, cyc);
    step();

    // Reset mid-WAIT: no ack for the aborted request, req0 wins afterwards
    model_lat = 60;
    set_req(1, 10'h0F0, 8'h05);
    op_q.push_back('{x: 10'h0F0, y: 8'h05});
    repeat (8) step();
    check("busy_before_rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_start", 32'(cos_start), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_cos_x", 32'(cos_x), 32'd0);
    req = '0;
    repeat (2) step();
    rst = 1'b0;
    model_lat = 5;
    set_req(0, 10'h0AA, 8'h07);
    set_req(3, 10'h3C0, 8'h08);
    expect_txn(0, 10'h0AA, 8'h07, cos_f(10'h0AA, 8'h07), 1'b0);
    expect_txn(3, 10'h3C0, 8'h08, cos_f(10'h3C0, 8'h08), 1'b0);
    wait_acks(2, 200, cyc);
    step();

`ifdef COS_TIMEOUT_EN
    // Watchdog: unit never ready -> ack TMO cycles after WAIT entry
    model_lat = 0;
    set_req(2, 10'h111, 8'h09);
    expect_txn(2, 10'h111, 8'h09, '0, 1'b1);
    wait_acks(1, 200, cyc);
    check("timeout_latency", 32'(cyc), 32'(3 + TMO));
    step();
`endif

    check("final_rsp_queue", 32'(rsp_q.size()), 32'd0);
    check("final_op_queue", 32'(op_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cosinus_arbiter.md
Name: cosinus_arbiter

Overview:
Round-robin scheduler that shares one Cosinus datapath (start/ready handshake, x[9:0], y[7:0], result[9:0]) among NREQ requesters. It latches the winning requester's operands and pulses the unit's start, then waits for ready. It captures the result and returns it to the winner with a one-cycle ack. It sits between the requesting control FSMs and the single Cosinus instance.

Parameters:
NREQ, 4, number of requesters (2..8)
XW, 10, operand x width
YW, 8, operand y width
RW, 10, result width
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with COS_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester request level
req_x  in  NREQ*XW  flattened operands x; slice i = bits [i*XW +: XW]
req_y  in  NREQ*YW  flattened operands y, same slicing
ack  out  NREQ  one-hot, one-cycle completion pulse
rsp_result  out  RW  result; valid only while any ack bit is 1
rsp_id  out  $clog2(NREQ)  index of the acked requester
busy  out  1  high in every state except IDLE
cos_start  out  1  start pulse to the Cosinus unit
cos_x  out  XW  operand x to the unit
cos_y  out  YW  operand y to the unit
cos_ready  in  1  unit done/idle flag
cos_result  in  RW  unit result

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; grant pointer last=NREQ-1, so requester 0 wins first.
- States: IDLE -> ISSUE -> ARM -> WAIT -> RESP -> IDLE.
- IDLE: if any req bit is 1, pick the first set bit scanning last+1, last+2, … modulo NREQ.
  - Register it as g and set last=g.
  - Latch req_x/req_y slice g into cos_x/cos_y.
  - Go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE: cos_start=1 for exactly this cycle, then go to ARM.
- ARM: cos_ready is ignored for this one cycle, giving the unit time to deassert ready. Go to WAIT.
- WAIT: on cos_ready=1, latch cos_result and go to RESP. Otherwise stay in WAIT.
- RESP: ack[g]=1, rsp_id=g, rsp_result=latched value for this cycle only, then go to IDLE.
- Outside RESP, ack=0. rsp_result and rsp_id hold their last values but are not valid.
- cos_x/cos_y hold stable from ISSUE through WAIT. Later changes on req_x/req_y do not affect the transaction in flight.
- Minimum latency: req sampled high in IDLE at edge N, with cos_ready already 1 in WAIT, gives ack high in the cycle after edge N+3 (4 cycles).
- Back-to-back: RESP -> IDLE costs one cycle, so the next start comes no earlier than 2 cycles after ack.
- Requester protocol:
  - Hold req and operands stable until ack.
  - Drop req in the cycle after ack, or be re-arbitrated as a new request.
- req dropped mid-transaction: the transaction still completes and ack[g] still pulses.
- Simultaneous requests: exactly one grant per transaction. Round-robin guarantees each active requester is served within NREQ transactions.
- Reset during any state: cos_start drops asynchronously; the in-flight result is discarded and no ack is issued.

Optional Feature:
COS_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter (cleared on WAIT entry) runs. When it reaches TIMEOUT_CYCLES without cos_ready, go to RESP.
  - In RESP: rsp_result=0 and rsp_err=1, alongside ack[g].
  - Adds output port rsp_err (1 bit, reset 0, valid with ack).
- Undefined: no counter and no rsp_err port; WAIT waits indefinitely.

Test Plan:
- Single request: req[0]=1, x=10'h100, y=8'h01; model returns 10'h2A5 after 20 cycles -> one cos_start pulse with cos_x=10'h100, cos_y=8'h01; ack[0] for 1 cycle, rsp_result=10'h2A5, rsp_id=0; busy low one cycle later.
- All four requesters assert in the same cycle, each with distinct x (10'h080,10'h100,10'h180,10'h200) -> service order 0,1,2,3; each ack carries the matching model result; exactly 4 start pulses.
- Fairness: req0 held high continuously, req2 asserted once -> grants 0,2,0,0…; req2 acked within 2 transactions.
- Operands change after grant: req_x slice 1 changes from 10'h180 to 10'h3FF during WAIT -> cos_x stays 10'h180; result corresponds to 10'h180.
- Reset mid-WAIT: assert rst 5 cycles into WAIT -> cos_start, busy and ack are 0 immediately; no ack for the aborted request; after release, next grant goes to req0.
- COS_TIMEOUT_EN: model never raises ready -> ack[g] exactly TIMEOUT_CYCLES=64 cycles after WAIT entry, rsp_err=1, rsp_result=0.
